camera_config_sequencer: RTL and testbench

// Downstream consumer of the camera configuration ROM. Walks the ROM from address 0 and

---
 rtl/camera_config_sequencer.sv | 107 ++++++++++
 tb/tb_camera_config_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_config_sequencer.sv
// Walks the camera configuration ROM from address 0 and issues each {reg,data} word to the
// SCCB write master over valid/ready; 16'hFFF0 inserts a fixed delay, 16'hFFFF ends the table.
module camera_config_sequencer #(
  parameter int unsigned DELAY_CYCLES = 250_000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_valid,
  input  logic        i_sccb_ready,
  output logic [7:0]  o_sccb_dev_addr,
  output logic [7:0]  o_sccb_reg_addr,
  output logic [7:0]  o_sccb_reg_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned    CntW    = $clog2(DELAY_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(DELAY_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StSend, StDelay, StDone} state_e;

  state_e          state_q;
  logic [7:0]      addr_q;
  logic            valid_q;
  logic [7:0]      reg_q;
  logic [7:0]      data_q;
  logic            busy_q;
  logic            done_q;
  logic [CntW-1:0] cnt_q;
  logic            advance;

  // Current entry finished: write accepted or delay expired.
  assign advance = (state_q == StSend && valid_q && i_sccb_ready) ||
                   (state_q == StDelay && cnt_q == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      addr_q  <= 8'h00;
      valid_q <= 1'b0;
      reg_q   <= 8'h00;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (i_start) begin
            addr_q  <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StFetch;
          end
        end
        StFetch: state_q <= StDecode;
        StDecode: begin
          if (i_rom_data == 16'hFFFF) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (i_rom_data == 16'hFFF0) begin
            cnt_q   <= CntLoad;
            state_q <= StDelay;
          end else begin
            reg_q   <= i_rom_data[15:8];
            data_q  <= i_rom_data[7:0];
            valid_q <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (i_sccb_ready) valid_q <= 1'b0;
        end
        StDelay: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
        end
        default: state_q <= StIdle;
      endcase

      // The last ROM address terminates the table rather than wrapping to 0.
      if (advance) begin
        if (addr_q == 8'hFF) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end else begin
          addr_q  <= addr_q + 8'h01;
          state_q <= StFetch;
        end
      end
    end
  end

  assign o_rom_addr      = addr_q;
  assign o_sccb_valid    = valid_q;
  assign o_sccb_dev_addr = DEV_ADDR;
  assign o_sccb_reg_addr = reg_q;
  assign o_sccb_reg_data = data_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Self-checking bench: behavioural ROM, directed scenarios plus randomized tables checked
// against a table-walk model of the expected SCCB writes and completion timing.
module tb_camera_config_sequencer;

  localparam int unsigned Delay = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        valid;
  logic        ready = 1'b0;
  logic [7:0]  dev_addr, reg_addr, reg_data;
  logic        busy, done;

  camera_config_sequencer #(.DELAY_CYCLES(Delay), .DEV_ADDR(8'h42)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .o_rom_addr      (rom_addr),
    .i_rom_data      (rom_data),
    .o_sccb_valid    (valid),
    .i_sccb_ready    (ready),
    .o_sccb_dev_addr (dev_addr),
    .o_sccb_reg_addr (reg_addr),
    .o_sccb_reg_data (reg_data),
    .o_busy          (busy),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int ready_mode = 0;  // 0: tied high, 1: random, 2: held low
  int stab_err = 0, drop_err = 0, dev_err = 0;
  logic        prev_v = 1'b0, prev_acc = 1'b0;
  logic [15:0] prev_pl = 16'h0;
  logic [15:0] got_w[$];
  int          got_t[$];
  logic [15:0] exp_w[$];
  int          exp_t[$];
  int          exp_done;
  logic [7:0]  exp_addr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) ready = 1'b1;
    else if (ready_mode == 1) ready = ($urandom_range(0, 3) != 0);
    else ready = 1'b0;
  end

  // Monitor: a transfer seen here is accepted on the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      prev_v   = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (done && done_cyc < 0) done_cyc = cyc;
      if (dev_addr != 8'h42) dev_err++;
      if (prev_v && !prev_acc) begin
        if (!valid) drop_err++;
        else if ({reg_addr, reg_data} != prev_pl) stab_err++;
      end
      if (valid && ready) begin
        got_w.push_back({reg_addr, reg_data});
        got_t.push_back(cyc + 1 - start_cyc);
      end
      prev_v   = valid;
      prev_acc = valid && ready;
      prev_pl  = {reg_addr, reg_data};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the table; cost in clock edges measured from the start-sampling edge.
  task automatic build_model();
    int t;
    bit ended;
    exp_w.delete();
    exp_t.delete();
    t = 0;
    ended = 0;
    exp_addr = 8'hFF;
    for (int a = 0; a < 256 && !ended; a++) begin
      if (rom[a] == 16'hFFFF) begin
        t += 2;
        exp_addr = 8'(a);
        ended = 1;
      end else if (rom[a] == 16'hFFF0) begin
        t += 2 + Delay;
      end else begin
        t += 3;
        exp_w.push_back(rom[a]);
        exp_t.push_back(t);
      end
    end
    exp_done = t;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
  endtask

  task automatic poke_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 5000; i++) begin
      if (done_cyc >= 0) break;
      @(negedge clk);
    end
    if (done_cyc < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = valid;
    end
    if (!seen) chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_writes(input int n, input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (got_w.size() >= n) break;
      @(negedge clk);
    end
    if (got_w.size() < n) chk({tag, "_wr_timeout"}, got_w.size(), n);
  endtask

  task automatic check_result(input string tag, input bit timed);
    int n;
    chk({tag, "_nwr"}, got_w.size(), exp_w.size());
    n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_wr%0d", tag, i), got_w[i], exp_w[i]);
      if (timed) chk($sformatf("%s_t%0d", tag, i), got_t[i], exp_t[i]);
    end
    if (timed) chk({tag, "_done_t"}, done_cyc - start_cyc, exp_done);
    #1;
    chk({tag, "_addr"}, rom_addr, exp_addr);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_valid"}, valid, 1'b0);
  endtask

  task automatic run_seq(input string tag, input bit timed);
    build_model();
    got_w.delete();
    got_t.delete();
    pulse_start();
    wait_done(tag);
    check_result(tag, timed);
  endtask

  task automatic load_t1();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1204;
    rom[3] = 16'hFFFF;
  endtask

  initial begin
    int hold;
    logic [15:0] w;
    int len;
    load_t1();
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", rom_addr, 8'h00);
    chk("rst_payload", {reg_addr, reg_data}, 16'h0000);
    chk("rst_dev", dev_addr, 8'h42);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: basic table with delay, ready tied high.
    ready_mode = 0;
    run_seq("t1", 1);

    // T2: back-pressure holds the request steady.
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1180;
    rom[1] = 16'hFFFF;
    build_model();
    got_w.delete();
    got_t.delete();
    ready_mode = 2;
    pulse_start();
    wait_valid("t2");
    hold = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (valid && {reg_addr, reg_data} == 16'h1180) hold++;
    end
    chk("t2_hold", hold, 20);
    ready_mode = 0;
    wait_done("t2");
    check_result("t2", 0);

    // T3: reset during DELAY aborts, then replay.
    load_t1();
    got_w.delete();
    got_t.delete();
    pulse_start();
    wait_writes(1, "t3");
    repeat (5) @(negedge clk);
    chk("t3_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t3_valid", valid, 1'b0);
    chk("t3_busy", busy, 1'b0);
    chk("t3_addr", rom_addr, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    run_seq("t3r", 1);

    // T4: start while busy is ignored; start in DONE reruns.
    build_model();
    got_w.delete();
    got_t.delete();
    ready_mode = 2;
    pulse_start();
    wait_valid("t4");
    poke_start();
    ready_mode = 0;
    wait_writes(1, "t4");
    repeat (6) @(negedge clk);
    poke_start();
    wait_done("t4");
    check_result("t4", 0);
    run_seq("t4r", 1);

    // T5: no terminator anywhere; stops at address 255.
    for (int i = 0; i < 256; i++) rom[i] = 16'h0100;
    run_seq("t5", 1);
    repeat (5) @(negedge clk);
    chk("t5_addr_hold", rom_addr, 8'hFF);

    // T6: empty table.
    rom[0] = 16'hFFFF;
    run_seq("t6", 1);

    // Randomized tables, alternating tied-high and random ready.
    for (int it = 0; it < 16; it++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < 256; i++) rom[i] = 16'(($urandom));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          w = 16'hFFF0;
        end else begin
          w = 16'($urandom);
          if (w[15:4] == 12'hFFF) w[15:8] = 8'h10;
        end
        rom[i] = w;
      end
      rom[len] = 16'hFFFF;
      ready_mode = it % 2;
      run_seq($sformatf("rnd%0d", it), (it % 2) == 0);
    end

    chk("stability", stab_err, 0);
    chk("no_drop", drop_err, 0);
    chk("dev_addr", dev_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
